// File: rtl/pipe_stage_skid_reg.sv
// Parametrised inter-stage register with a 2-entry skid buffer,
// synchronous flush and sticky interrupt capture.
module pipe_stage_skid_reg #(
   parameter int DATA_W = 59,
   parameter int CTRL_W = 35,
   parameter int INT_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [INT_W-1:0]  int_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [INT_W-1:0]  out_int,
   output logic [1:0]        occupancy
);

   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic [CTRL_W-1:0] m_ctrl;
   logic [INT_W-1:0]  m_int;

   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic [CTRL_W-1:0] s_ctrl;
   logic [INT_W-1:0]  s_int;

   logic [INT_W-1:0]  pend;
   logic [INT_W-1:0]  int_cap;
   logic              accept;
   logic              take;

   assign in_ready  = !s_valid;
   assign accept    = in_valid & in_ready & !flush;
   assign take      = m_valid & out_ready;
   assign int_cap   = pend | int_in;

   assign out_valid = m_valid;
   assign out_data  = m_data;
   assign out_ctrl  = m_valid ? m_ctrl : '0;
   assign out_int   = m_valid ? m_int : '0;
   assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

   // Pending flags survive flushes; only an accepted word drains them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= '0;
      end else if (accept) begin
         pend <= '0;
      end else begin
         pend <= int_cap;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_ctrl  <= '0;
         m_int   <= '0;
         s_valid <= 1'b0;
         s_data  <= '0;
         s_ctrl  <= '0;
         s_int   <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (!m_valid || take) begin
         if (s_valid) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_ctrl  <= s_ctrl;
            m_int   <= s_int;
            s_valid <= accept;
            if (accept) begin
               s_data <= in_data;
               s_ctrl <= in_ctrl;
               s_int  <= int_cap;
            end
         end else begin
            m_valid <= accept;
            if (accept) begin
               m_data <= in_data;
               m_ctrl <= in_ctrl;
               m_int  <= int_cap;
            end
         end
      end else if (accept) begin
         s_valid <= 1'b1;
         s_data  <= in_data;
         s_ctrl  <= in_ctrl;
         s_int   <= int_cap;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: streaming, skid,
// flush, interrupt capture and asynchronous reset.
module tb_pipe_stage_skid_reg;

   localparam int DATA_W = 59;
   localparam int CTRL_W = 35;
   localparam int INT_W  = 2;

   logic              clk;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic [INT_W-1:0]  int_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [INT_W-1:0]  out_int;
   logic [1:0]        occupancy;

   int n_chk;
   int n_fail;

   pipe_stage_skid_reg #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .INT_W (INT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .int_in   (int_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ctrl (out_ctrl),
      .out_int  (out_int),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d,
                        input logic [63:0] c);
      in_valid = v;
      in_data  = d[DATA_W-1:0];
      in_ctrl  = c[CTRL_W-1:0];
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_ov"}, 64'(out_valid), 64'd0);
      chk({tag, "_oc"}, 64'(out_ctrl), 64'd0);
      chk({tag, "_oi"}, 64'(out_int), 64'd0);
      chk({tag, "_occ"}, 64'(occupancy), 64'd0);
      chk({tag, "_ir"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      reset     = 1'b0;
      flush     = 1'b0;
      int_in    = '0;
      out_ready = 1'b0;
      drive(1'b0, 0, 0);
      #12;
      chk_empty("rst");
      chk("rst_od", 64'(out_data), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // 1: single word then streaming
      out_ready = 1'b1;
      drive(1'b1, 5, 1);
      step();
      chk("t1_ov", 64'(out_valid), 64'd1);
      chk("t1_oc", 64'(out_ctrl), 64'd1);
      chk("t1_od", 64'(out_data), 64'd5);
      chk("t1_occ", 64'(occupancy), 64'd1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 64'(100 + i), 64'(i + 2));
         step();
         chk("t1_sd", 64'(out_data), 64'(100 + i));
         chk("t1_sc", 64'(out_ctrl), 64'(i + 2));
         chk("t1_sv", 64'(out_valid), 64'd1);
      end
      drive(1'b0, 0, 0);
      step();
      chk_empty("t1_end");

      // 2: skid fill, backpressure, drain in order
      out_ready = 1'b0;
      drive(1'b1, 64'hA, 64'hA);
      step();
      chk("t2_occ1", 64'(occupancy), 64'd1);
      chk("t2_ir1", 64'(in_ready), 64'd1);
      drive(1'b1, 64'hB, 64'hB);
      step();
      chk("t2_occ2", 64'(occupancy), 64'd2);
      chk("t2_ir2", 64'(in_ready), 64'd0);
      drive(1'b1, 64'hC, 64'hC);
      step();
      chk("t2_hold_occ", 64'(occupancy), 64'd2);
      chk("t2_hold_od", 64'(out_data), 64'hA);
      out_ready = 1'b1;
      #1;
      chk("t2_a_od", 64'(out_data), 64'hA);
      step();
      chk("t2_b_od", 64'(out_data), 64'hB);
      chk("t2_b_ir", 64'(in_ready), 64'd1);
      chk("t2_b_occ", 64'(occupancy), 64'd1);
      step();
      chk("t2_c_od", 64'(out_data), 64'hC);
      chk("t2_c_oc", 64'(out_ctrl), 64'hC);
      drive(1'b0, 0, 0);
      step();
      chk_empty("t2_end");

      // 3: flush with two entries held, then flush with word offered
      out_ready = 1'b0;
      drive(1'b1, 64'h21, 64'h21);
      step();
      drive(1'b1, 64'h22, 64'h22);
      step();
      chk("t3_occ", 64'(occupancy), 64'd2);
      flush = 1'b1;
      drive(1'b1, 64'hD, 64'hD);
      step();
      flush = 1'b0;
      drive(1'b0, 0, 0);
      chk_empty("t3_fl");
      flush = 1'b1;
      drive(1'b1, 64'hD, 64'hD);
      step();
      flush = 1'b0;
      drive(1'b0, 0, 0);
      chk_empty("t3_fl2");
      step();
      chk_empty("t3_noD");

      // 4: pending interrupt survives a flush
      out_ready = 1'b1;
      int_in = 2'b01;
      step();
      int_in = 2'b00;
      flush  = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b1, 64'hE, 64'hE);
      step();
      chk("t4_e_od", 64'(out_data), 64'hE);
      chk("t4_e_oi", 64'(out_int), 64'd1);
      drive(1'b1, 64'h44, 64'h44);
      step();
      chk("t4_g_od", 64'(out_data), 64'h44);
      chk("t4_g_oi", 64'(out_int), 64'd0);
      drive(1'b0, 0, 0);
      step();
      chk_empty("t4_end");

      // 5: same-cycle interrupt merges with pending
      int_in = 2'b01;
      step();
      int_in = 2'b10;
      drive(1'b1, 64'hF, 64'hF);
      step();
      int_in = 2'b00;
      chk("t5_f_od", 64'(out_data), 64'hF);
      chk("t5_f_oi", 64'(out_int), 64'd3);
      drive(1'b1, 64'h55, 64'h55);
      step();
      chk("t5_h_od", 64'(out_data), 64'h55);
      chk("t5_h_oi", 64'(out_int), 64'd0);
      drive(1'b0, 0, 0);
      step();

      // 6: async reset with both entries full
      out_ready = 1'b0;
      drive(1'b1, 64'h61, 64'h61);
      step();
      drive(1'b1, 64'h62, 64'h62);
      step();
      chk("t6_occ", 64'(occupancy), 64'd2);
      drive(1'b0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk_empty("t6_rst");
      chk("t6_od", 64'(out_data), 64'd0);
      step();
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      chk_empty("t6_rel");
      drive(1'b1, 64'h66, 64'h7);
      step();
      chk("t6_k_ov", 64'(out_valid), 64'd1);
      chk("t6_k_od", 64'(out_data), 64'h66);
      chk("t6_k_oc", 64'(out_ctrl), 64'h7);
      chk("t6_k_occ", 64'(occupancy), 64'd1);
      drive(1'b0, 0, 0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised inter-stage pipeline register, the generalised replacement for the fixed decode/execute latch. Carries a data payload, a control word and interrupt flags between any two stages. Uses a valid/ready handshake with a 2-entry skid buffer so `in_ready` is registered. Supports synchronous flush (bubble insertion) and sticky interrupt capture, so a pulsed interrupt is never lost while the stage is stalled or flushed.

Parameters:
DATA_W, 59, payload width (Imm16 + shmnt5 + Rs_data16 + Rd_data16 + Rd3 + Rs3)
CTRL_W, 35, control-signal word width; all-zero = NOP
INT_W, 2, number of interrupt lines

Ports:
clk  input  1  single clock; all state changes on posedge
reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately
flush  input  1  synchronous flush; drops stage contents and any same-cycle input
in_valid  input  1  upstream word present
in_ready  output  1  stage can accept a word this cycle
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control word
int_in  input  INT_W  interrupt pulses, any cycle, independent of handshake
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts output word
out_data  output  DATA_W  payload of head entry
out_ctrl  output  CTRL_W  control of head entry; forced 0 when `out_valid`=0
out_int  output  INT_W  interrupt flags attached to head entry; 0 when `out_valid`=0
occupancy  output  2  entries held (0..2)

Behaviour:
- Storage: main entry M {data, ctrl, int, valid} drives the outputs. Skid entry S {data, ctrl, int, valid} holds overflow.
- Handshake signals:
  - accept = `in_valid` & `in_ready` & !`flush`
  - take = `out_valid` & `out_ready`
- `in_ready` = !S.valid. It comes from a register, not from `out_ready`.
- `out_valid` = M.valid; `occupancy` = M.valid + S.valid.
- Per posedge, when not flushing, exactly one of these applies:
  - M empty or take, and S valid: M<=S, S<=incoming if accept, else S invalid.
  - M empty or take, and S empty: M<=incoming if accept, else M invalid.
  - M full and no take, and accept: S<=incoming. `in_ready` drops the next cycle.
  - Otherwise: hold.
- Latency: a word accepted in cycle t into an empty stage appears on the outputs in cycle t+1. Throughput is 1 word/cycle while `out_ready`=1.
- Ordering is FIFO; no word is ever duplicated or reordered.
- Interrupts:
  - Pending register P <= P | `int_in` each cycle.
  - An accepted word's int field = P | `int_in`, and P clears on that edge (any new `int_in` in that same cycle is already included).
  - `flush` and take never clear P, so interrupts survive flushes.
- Flush:
  - On a posedge with `flush`=1, M.valid and S.valid clear, any input offered that cycle is dropped, and P is kept.
  - Next cycle: `out_valid`=0, `out_ctrl`=0, `in_ready`=1.
  - `flush` takes priority over accept and take (take still counts as consumed downstream).
- Bubble: whenever M is invalid, `out_ctrl` and `out_int` are 0 so downstream sees a NOP. `out_data` keeps its last value (don't care).
- Reset (`reset`=0, async):
  - M, S and P are cleared and their data zeroed.
  - Outputs: `out_valid`=0, `out_data`=0, `out_ctrl`=0, `out_int`=0, `occupancy`=0, `in_ready`=1.
  - Reset mid-transfer discards both entries. Deassertion is synchronous to `clk`; the first accept is possible on the first posedge with `reset`=1.
- `out_ready` may toggle while `out_valid`=1; the head must stay stable until take.

Test Plan:
1. Reset release, then `in_valid`=1 with `in_ctrl`=35'h1, `in_data`=5, `out_ready`=1 -> next cycle `out_valid`=1, `out_ctrl`=1, `out_data`=5, `occupancy`=1; streaming 10 words gives 10 outputs on consecutive cycles in order.
2. `out_ready`=0, push A then B -> `occupancy`=2, `in_ready`=0, C held upstream. Raise `out_ready` -> outputs A, B, C in consecutive cycles; `in_ready` returns to 1 the cycle after A is taken.
3. Two entries held, pulse `flush` with `in_valid`=1 (word D) -> next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1; D never appears.
4. `int_in`=2'b01 pulsed for 1 cycle while `in_valid`=0, then `flush`, then word E accepted -> E exits with `out_int`=01; the following word exits with `out_int`=00.
5. `int_in`=2'b10 pulsed in the same cycle word F is accepted while P=01 -> F exits with `out_int`=11 and P=0 afterwards.
6. `reset`=0 asserted between clock edges with `occupancy`=2 -> outputs zero immediately (before the next posedge), `in_ready`=1; after release the stage is empty and first accept works.
